lo_sequencer: RTL and testbench
===============================

LO_SEQUENCER -- requirements
Module: lo_sequencer

Interface
REQ-001 Parameter PHASE_INIT, default 2'd0: LO phase loaded on every entry to RUN.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 en_i  in  1  run request from control; level-sensitive.
REQ-005 samp_valid_i  in  1  interpolator sample valid.
REQ-006 samp_i  in  `T_BITS  interpolator sample, signed Q(`T_BITS-`F_BITS).`F_BITS.
REQ-007 samp_ready_o  out  1  sample accepted on the cycle samp_valid_i and samp_ready_o are both high.
REQ-008 mix_samp_o  out  `T_BITS  registered sample to the mixer input.
REQ-009 lo_o  out  2  LO code to the mixer: 2'b01 = +1, 2'b10 = -1, 2'b00 = 0; 2'b11 is never driven.
REQ-010 mix_valid_o  out  1  mix_samp_o and lo_o hold a valid pair.
REQ-011 mix_ready_i  in  1  downstream consumed the pair on the cycle mix_valid_o and mix_ready_i are both high.
REQ-012 phase_o  out  2  current LO phase counter.
REQ-013 period_cnt_o  out  8  completed LO periods, wrapping.
REQ-014 busy_o  out  1  high in RUN or DRAIN.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, RUN and DRAIN, with transitions: IDLE->RUN when en_i=1; RUN->DRAIN when en_i=0; DRAIN->IDLE when mix_valid_o=0 and en_i=0; DRAIN->RUN when mix_valid_o=0 and en_i=1.
REQ-016 Every entry to RUN SHALL load phase_o with PHASE_INIT.
REQ-017 samp_ready_o SHALL equal (state==RUN) && (!mix_valid_o || mix_ready_i), combinationally.
REQ-018 On acceptance, the block SHALL register samp_i into mix_samp_o, register the code for the current phase into lo_o, set mix_valid_o, and advance phase_o by 1 modulo 4, giving a latency of 1 cycle.
REQ-019 The phase-to-code map SHALL be: 0 -> 01, 1 -> 00, 2 -> 10, 3 -> 00 (an fs/4 cosine).
REQ-020 On acceptance at phase 3, period_cnt_o SHALL increment, wrapping from 255 to 0.
REQ-021 On a consume with no same-cycle acceptance, mix_valid_o SHALL clear and lo_o SHALL be forced to 00.
REQ-022 On simultaneous consume and acceptance, the new pair SHALL replace the old pair and mix_valid_o SHALL stay 1, with no bubble.
REQ-023 While mix_valid_o=1 and mix_ready_i=0, mix_samp_o and lo_o SHALL hold stable.
REQ-024 In DRAIN, no sample SHALL be accepted, and the held pair SHALL remain until consumed.
REQ-025 The phase counter SHALL NOT advance without an acceptance, and SHALL hold in IDLE and DRAIN.
REQ-026 An en_i toggle during RUN SHALL be observed on the next edge, and a sample accepted on that same edge SHALL complete normally.

Reset
REQ-027 While rst is high, the block SHALL hold: state=IDLE, mix_valid_o=0, mix_samp_o=0, lo_o=00, phase_o=PHASE_INIT, period_cnt_o=0, busy_o=0.
REQ-028 A reset mid-stream SHALL discard any held pair without asserting mix_valid_o.
REQ-029 The first acceptance after reset release SHALL occur no earlier than the cycle after the cycle in which RUN is entered.

Configuration
REQ-030 With `LO_QUAD_EN defined, the block SHALL add output lo_q_o (2 bits) registered alongside lo_o, with map 0 -> 00, 1 -> 10, 2 -> 00, 3 -> 01 (an fs/4 -sine), forced to 00 whenever mix_valid_o=0.
REQ-031 Without `LO_QUAD_EN, lo_q_o SHALL NOT exist and no quadrature logic SHALL be synthesized.

Structure
REQ-032 `T_BITS, `F_BITS, the LO code constants (LO_POS=2'b01, LO_NEG=2'b10, LO_ZERO=2'b00) and the state encodings SHALL reside in parameters.vh.
REQ-033 A single sub-module, lo_phase_lut (phase in, lo code(s) out, combinational), SHALL implement the map; everything else SHALL be in lo_sequencer.

Verification
REQ-034 Scenario: reset, then en_i=1 with samples 1,2,3,4,5 continuously valid and mix_ready_i=1 -> lo_o sequence 01,00,10,00,01, each one cycle after its sample; period_cnt_o=1 after the 4th sample.
REQ-035 Scenario: mix_ready_i=0 for 3 cycles with a pair held -> samp_ready_o=0, and mix_samp_o, lo_o and phase_o stable.
REQ-036 Scenario: en_i dropped while a pair is held and mix_ready_i=0 -> DRAIN with busy_o=1; after one consume, IDLE, busy_o=0 and lo_o=00.
REQ-037 Scenario: en_i re-raised during DRAIN -> return to RUN after the drain, with phase_o=PHASE_INIT and the next sample coded 01.
REQ-038 Scenario: rst asserted mid-stream at phase 2 -> all outputs at reset values on the same cycle; no spurious mix_valid_o after release.
REQ-039 Scenario (`LO_QUAD_EN defined): 4 samples -> lo_q_o sequence 00,10,00,01, aligned with lo_o.

Source files
------------

// File: rtl/lo_sequencer_pkg.sv
// Types and constants for the fs/4 LO sequencer (optional quadrature: LO_QUAD_EN).
package lo_sequencer_pkg;

`include "parameters.vh"

  localparam int T_W = `T_BITS;
  localparam int F_W = `F_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN
  } state_t;

endpackage

// File: rtl/lo_phase_lut.sv
// Combinational phase -> LO code map: fs/4 cosine, plus fs/4 -sine when LO_QUAD_EN is defined.
module lo_phase_lut
  import lo_sequencer_pkg::*;
(
  input  logic [1:0] phase,
`ifdef LO_QUAD_EN
  output logic [1:0] lo_q_code,
`endif
  output logic [1:0] lo_i_code
);

  always_comb begin
    lo_i_code = LO_ZERO;
    case (phase)
      2'd0:    lo_i_code = LO_POS;
      2'd2:    lo_i_code = LO_NEG;
      default: lo_i_code = LO_ZERO;
    endcase
  end

`ifdef LO_QUAD_EN
  always_comb begin
    lo_q_code = LO_ZERO;
    case (phase)
      2'd1:    lo_q_code = LO_NEG;
      2'd3:    lo_q_code = LO_POS;
      default: lo_q_code = LO_ZERO;
    endcase
  end
`endif

endmodule

// File: rtl/parameters.vh
// Shared widths, LO code constants and FSM encodings for the LO sequencer.
// Included once, inside lo_sequencer_pkg.
`ifndef LO_PARAMETERS_VH
`define LO_PARAMETERS_VH

`define T_BITS 16
`define F_BITS 14

localparam logic [1:0] LO_POS  = 2'b01;
localparam logic [1:0] LO_NEG  = 2'b10;
localparam logic [1:0] LO_ZERO = 2'b00;

localparam logic [1:0] ST_IDLE  = 2'd0;
localparam logic [1:0] ST_RUN   = 2'd1;
localparam logic [1:0] ST_DRAIN = 2'd2;

`endif

// File: rtl/lo_sequencer.sv
// Pairs interpolator samples with an fs/4 LO code for the mixer; 1-cycle latency, valid/ready on both sides.
// Optional quadrature output lo_q_o is built only when LO_QUAD_EN is defined.
module lo_sequencer
  import lo_sequencer_pkg::*;
#(
  parameter logic [1:0] PHASE_INIT = 2'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                samp_valid_i,
  input  logic [`T_BITS-1:0]  samp_i,
  output logic                samp_ready_o,
  output logic [`T_BITS-1:0]  mix_samp_o,
  output logic [1:0]          lo_o,
  output logic                mix_valid_o,
  input  logic                mix_ready_i,
  output logic [1:0]          phase_o,
  output logic [7:0]          period_cnt_o,
`ifdef LO_QUAD_EN
  output logic [1:0]          lo_q_o,
`endif
  output logic                busy_o
);

  state_t state, state_nxt;
  logic   accept;
  logic   consume;
  logic   run_entry;
  logic [1:0] lo_i_code;
`ifdef LO_QUAD_EN
  logic [1:0] lo_q_code;
`endif

  lo_phase_lut u_lut (
    .phase     (phase_o),
`ifdef LO_QUAD_EN
    .lo_q_code (lo_q_code),
`endif
    .lo_i_code (lo_i_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en_i) state_nxt = S_RUN;
      S_RUN:   if (!en_i) state_nxt = S_DRAIN;
      S_DRAIN: if (!mix_valid_o) state_nxt = en_i ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state == S_RUN) || (state == S_DRAIN);
    samp_ready_o = (state == S_RUN) && (!mix_valid_o || mix_ready_i);
  end

  assign accept    = samp_ready_o && samp_valid_i;
  assign consume   = mix_valid_o && mix_ready_i;
  assign run_entry = (state != S_RUN) && (state_nxt == S_RUN);

  // Acceptance only happens in RUN, so it never collides with a RUN entry reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_o      <= PHASE_INIT;
      period_cnt_o <= 8'd0;
    end else if (run_entry) begin
      phase_o      <= PHASE_INIT;
    end else if (accept) begin
      phase_o      <= phase_o + 2'd1;
      if (phase_o == 2'd3) period_cnt_o <= period_cnt_o + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_valid_o <= 1'b0;
      mix_samp_o  <= '0;
      lo_o        <= LO_ZERO;
    end else if (accept) begin
      mix_valid_o <= 1'b1;
      mix_samp_o  <= samp_i;
      lo_o        <= lo_i_code;
    end else if (consume) begin
      mix_valid_o <= 1'b0;
      lo_o        <= LO_ZERO;
    end
  end

`ifdef LO_QUAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          lo_q_o <= LO_ZERO;
    else if (accept)  lo_q_o <= lo_q_code;
    else if (consume) lo_q_o <= LO_ZERO;
  end
`endif

endmodule

// File: tb/tb_lo_sequencer.sv
// Randomized bench for lo_sequencer against a cycle-level behavioural model of the LO pairing rules.
module tb_lo_sequencer;
  import lo_sequencer_pkg::*;

  localparam logic [1:0] PINIT = 2'd0;

  logic           clk = 1'b0;
  logic           rst;
  logic           en_i, samp_valid_i, mix_ready_i;
  logic [T_W-1:0] samp_i;
  logic           samp_ready_o, mix_valid_o, busy_o;
  logic [T_W-1:0] mix_samp_o;
  logic [1:0]     lo_o, phase_o;
  logic [7:0]     period_cnt_o;
`ifdef LO_QUAD_EN
  logic [1:0]     lo_q_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lo_sequencer #(.PHASE_INIT(PINIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .samp_valid_i (samp_valid_i),
    .samp_i       (samp_i),
    .samp_ready_o (samp_ready_o),
    .mix_samp_o   (mix_samp_o),
    .lo_o         (lo_o),
    .mix_valid_o  (mix_valid_o),
    .mix_ready_i  (mix_ready_i),
    .phase_o      (phase_o),
    .period_cnt_o (period_cnt_o),
`ifdef LO_QUAD_EN
    .lo_q_o       (lo_q_o),
`endif
    .busy_o       (busy_o)
  );

  // Reference model: mode 0=idle 1=run 2=drain; LO as signed waveform values.
  int             m_mode;
  bit             m_vld;
  logic [T_W-1:0] m_samp;
  int             m_lo, m_lq;
  int             m_phase, m_per;
  int             cos_tab [4] = '{1, 0, -1, 0};
  int             msin_tab[4] = '{0, -1, 0, 1};

  function automatic logic [1:0] enc(input int v);
    return (v > 0) ? 2'b01 : (v < 0) ? 2'b10 : 2'b00;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_vld = 0; m_samp = '0; m_lo = 0; m_lq = 0;
    m_phase = PINIT; m_per = 0;
  endtask

  task automatic check_outputs();
    check_val("mix_valid", mix_valid_o, m_vld);
    check_val("mix_samp", mix_samp_o, m_samp);
    check_val("lo", lo_o, enc(m_lo));
    check_val("phase", phase_o, m_phase);
    check_val("period_cnt", period_cnt_o, m_per);
    check_val("busy", busy_o, m_mode != 0);
`ifdef LO_QUAD_EN
    check_val("lo_q", lo_q_o, enc(m_lq));
`endif
  endtask

  // One clock: drive at negedge, check ready combinationally, check registers at next negedge.
  task automatic step(input logic en, input logic v, input logic [T_W-1:0] s,
                      input logic r, output bit acc);
    bit cons, held;
    int nmode;
    en_i = en; samp_valid_i = v; samp_i = s; mix_ready_i = r;
    #1;
    check_val("samp_ready", samp_ready_o, (m_mode == 1) && (!m_vld || r));
    acc  = (m_mode == 1) && (!m_vld || r) && v;
    cons = m_vld && r;
    held = m_vld;
    @(posedge clk);
    if (acc) begin
      m_samp = s; m_lo = cos_tab[m_phase]; m_lq = msin_tab[m_phase]; m_vld = 1;
      if (m_phase == 3) m_per = (m_per + 1) % 256;
      m_phase = (m_phase + 1) % 4;
    end else if (cons) begin
      m_vld = 0; m_lo = 0; m_lq = 0;
    end
    nmode = m_mode;
    if (m_mode == 0 && en) nmode = 1;
    else if (m_mode == 1 && !en) nmode = 2;
    else if (m_mode == 2 && !held) nmode = en ? 1 : 0;
    if (nmode == 1 && m_mode != 1) m_phase = PINIT;
    m_mode = nmode;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  logic [1:0] lo_seq [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

  initial begin
    bit acc;
    int k, guard;
    rst = 1'b0; en_i = 0; samp_valid_i = 0; samp_i = '0; mix_ready_i = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Five back-to-back samples with ready held high.
    k = 1; guard = 0;
    while (k <= 5 && guard < 20) begin
      step(1'b1, 1'b1, T_W'(k), 1'b1, acc);
      if (acc) begin
        check_val("seq_lo", lo_o, lo_seq[k-1]);
        check_val("seq_samp", mix_samp_o, k);
        if (k == 4) check_val("seq_period", period_cnt_o, 1);
        k++;
      end
      guard++;
    end
    check_val("seq_done", k, 6);

    // Stall for three cycles with a pair held.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 16'h0AAA, 1'b0, acc);
      check_val("stall_samp", mix_samp_o, 5);
    end

    // Drop en while held, then consume once.
    step(1'b0, 1'b1, 16'h0BBB, 1'b0, acc);
    check_val("drain_busy", busy_o, 1);
    step(1'b0, 1'b1, 16'h0BBB, 1'b1, acc);
    step(1'b0, 1'b0, 16'h0000, 1'b0, acc);
    check_val("drain_idle", busy_o, 0);
    check_val("drain_lo", lo_o, 2'b00);

    // Re-raise en during drain: next sample restarts at phase PHASE_INIT.
    step(1'b1, 1'b1, 16'h0011, 1'b1, acc);
    step(1'b1, 1'b1, 16'h0012, 1'b0, acc);
    step(1'b1, 1'b1, 16'h0012, 1'b0, acc);
    step(1'b0, 1'b1, 16'h0013, 1'b0, acc);
    step(1'b1, 1'b1, 16'h0014, 1'b1, acc);
    step(1'b1, 1'b1, 16'h0015, 1'b1, acc);
    check_val("reentry_phase", phase_o, PINIT);
    step(1'b1, 1'b1, 16'h0016, 1'b1, acc);
    check_val("reentry_acc", acc, 1);
    check_val("reentry_lo", lo_o, 2'b01);

    // Reach phase 2 and reset mid-stream.
    guard = 0;
    while (phase_o != 2'd2 && guard < 10) begin
      step(1'b1, 1'b1, 16'h0100, 1'b1, acc);
      guard++;
    end
    check_val("mid_phase", phase_o, 2);
    do_reset();
    step(1'b1, 1'b0, 16'h0000, 1'b0, acc);
    check_val("post_rst_vld", mix_valid_o, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           T_W'($urandom), $urandom_range(0, 2) != 0, acc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
